interconn_rxq: RTL and testbench

INTERCONN_RXQ -- requirements
Module: interconn_rxq

---
 rtl/interconn_pkg.sv | 23 ++
 rtl/interconn_rxfifo.sv | 73 +++++++
 rtl/interconn_rxq.sv | 145 ++++++++++++++
 tb/tb_interconn_rxq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interconn_pkg.sv
// -----------------------------------------------------------------------------
// interconn_pkg
// Shared definitions for the MVU interconnect receive path.
//   IC_N / IC_W / IC_BADDR : default MVU count, data width, memory address width
//   ic_entry_t             : one queued write, {from, addr, word}, at the
//                            default widths
//   IC_ENTRY_W             : packed width of ic_entry_t
// -----------------------------------------------------------------------------
package interconn_pkg;

  localparam int IC_N     = 8;
  localparam int IC_W     = 64;
  localparam int IC_BADDR = 15;

  typedef struct packed {
    logic [IC_N-1:0]     from;
    logic [IC_BADDR-1:0] addr;
    logic [IC_W-1:0]     word;
  } ic_entry_t;

  localparam int IC_ENTRY_W = $bits(ic_entry_t);

endpackage

// File: rtl/interconn_rxfifo.sv
// -----------------------------------------------------------------------------
// interconn_rxfifo
// Plain circular FIFO holding received interconnect entries.
//   clk, clr     : clock, asynchronous active-high reset (pointers/count only)
//   push, din    : write din at the write pointer (caller guarantees room or
//                  a same-edge pop)
//   pop, dout    : dout is the head entry; pop advances past it
//   count        : occupancy, 0..DEPTH
//   full, empty  : count == DEPTH, count == 0
// -----------------------------------------------------------------------------
module interconn_rxfifo
  import interconn_pkg::*;
#(
  parameter int EW    = IC_ENTRY_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [EW-1:0] din,
  input  logic          pop,
  output logic [EW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  // Storage is not reset; only the pointers and count define validity.
  logic [EW-1:0] slots [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, a push+pop targets the head slot: the head is read out
  // (combinationally) before the edge overwrites it, so no data is lost.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr_q] <= din;
  end

  assign dout  = slots[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/interconn_rxq.sv
// -----------------------------------------------------------------------------
// interconn_rxq
// Receive queue between the MVU interconnect and the local memory write port.
// Incoming writes are queued (no backpressure) and drained into memory
// whenever the local MVU is not using the write port.
//   clk, clr                          : clock, asynchronous active-high reset
//   recv_en/from/addr/word            : incoming interconnect write
//   mem_busy                          : local MVU owns the memory port
//   ovf_clr                           : clears overflow / err_from
//   mem_we/addr/wdata/from            : registered memory write
//   count, full                       : queue occupancy status
//   overflow                          : sticky, a word was dropped
//   err_from                          : sticky, recv_from was not one-hot
// -----------------------------------------------------------------------------
module interconn_rxq
  import interconn_pkg::*;
#(
  parameter int N     = IC_N,
  parameter int W     = IC_W,
  parameter int BADDR = IC_BADDR,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     recv_en,
  input  logic [N-1:0]             recv_from,
  input  logic [BADDR-1:0]         recv_addr,
  input  logic [W-1:0]             recv_word,
  input  logic                     mem_busy,
  input  logic                     ovf_clr,
  output logic                     mem_we,
  output logic [BADDR-1:0]         mem_addr,
  output logic [W-1:0]             mem_wdata,
  output logic [N-1:0]             mem_from,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     err_from
);

  localparam int EW = N + BADDR + W;

  // Same layout as ic_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [N-1:0]     from;
    logic [BADDR-1:0] addr;
    logic [W-1:0]     word;
  } entry_t;

  entry_t push_entry;
  entry_t head_entry;
  logic [EW-1:0] head_bits;

  logic fifo_full;
  logic fifo_empty;
  logic do_push;
  logic do_pop;
  logic from_onehot;

  logic             mem_we_q,    mem_we_d;
  logic [BADDR-1:0] mem_addr_q,  mem_addr_d;
  logic [W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [N-1:0]     mem_from_q,  mem_from_d;
  logic             overflow_q,  overflow_d;
  logic             err_from_q,  err_from_d;

  always_comb begin
    push_entry.from = recv_from;
    push_entry.addr = recv_addr;
    push_entry.word = recv_word;
  end

  assign head_entry = entry_t'(head_bits);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign from_onehot = (recv_from != '0) && ((recv_from & (recv_from - N'(1))) == '0);

  assign do_pop  = !fifo_empty && !mem_busy;
  // A full queue still accepts a word if the head leaves at the same edge.
  assign do_push = recv_en && (!fifo_full || do_pop);

  interconn_rxfifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (do_push),
    .din   (push_entry),
    .pop   (do_pop),
    .dout  (head_bits),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    mem_we_d    = do_pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_from_d  = mem_from_q;
    if (do_pop) begin
      mem_addr_d  = head_entry.addr;
      mem_wdata_d = head_entry.word;
      mem_from_d  = head_entry.from;
    end

    // Set events win over a same-edge clear.
    overflow_d = overflow_q;
    err_from_d = err_from_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
      err_from_d = 1'b0;
    end
    if (recv_en && !do_push) overflow_d = 1'b1;
    if (recv_en && !from_onehot) err_from_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_from_q  <= '0;
      overflow_q  <= 1'b0;
      err_from_q  <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_from_q  <= mem_from_d;
      overflow_q  <= overflow_d;
      err_from_q  <= err_from_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_from  = mem_from_q;
  assign full      = fifo_full;
  assign overflow  = overflow_q;
  assign err_from  = err_from_q;

endmodule

// File: tb/tb_interconn_rxq.sv
// -----------------------------------------------------------------------------
// tb_interconn_rxq
// Directed bench for interconn_rxq at N=8, W=64, BADDR=15, DEPTH=4.
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_interconn_rxq;

  logic        clk = 1'b0;
  logic        clr;
  logic        recv_en;
  logic [7:0]  recv_from;
  logic [14:0] recv_addr;
  logic [63:0] recv_word;
  logic        mem_busy;
  logic        ovf_clr;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_from;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic        err_from;

  int tests  = 0;
  int failed = 0;

  interconn_rxq #(
    .N     (8),
    .W     (64),
    .BADDR (15),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .recv_en   (recv_en),
    .recv_from (recv_from),
    .recv_addr (recv_addr),
    .recv_word (recv_word),
    .mem_busy  (mem_busy),
    .ovf_clr   (ovf_clr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_from  (mem_from),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .err_from  (err_from)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  function automatic logic [7:0] from_of(input int a);
    return 8'(1) << (a % 8);
  endfunction

  task automatic drive_push(input int a);
    recv_en   = 1'b1;
    recv_addr = 15'(a);
    recv_word = word_of(a);
    recv_from = from_of(a);
  endtask

  initial begin
    clr = 1'b1; recv_en = 1'b0; recv_from = '0; recv_addr = '0;
    recv_word = '0; mem_busy = 1'b0; ovf_clr = 1'b0;

    // Reset state
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_from", 64'(mem_from), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_err", 64'(err_from), 64'd0);
    @(negedge clk);
    clr = 1'b0;

    // Single word: two-edge latency, one pulse
    recv_en = 1'b1; recv_from = 8'h08; recv_addr = 15'd7;
    recv_word = 64'hdeadbeefdeadbeef;
    step();
    check("single_e0_we", 64'(mem_we), 64'd0);
    check("single_e0_count", 64'(count), 64'd1);
    recv_en = 1'b0;
    step();
    check("single_we", 64'(mem_we), 64'd1);
    check("single_addr", 64'(mem_addr), 64'd7);
    check("single_from", 64'(mem_from), 64'h08);
    check("single_data", mem_wdata, 64'hdeadbeefdeadbeef);
    step();
    check("single_we_off", 64'(mem_we), 64'd0);
    check("single_hold_addr", 64'(mem_addr), 64'd7);
    check("single_count0", 64'(count), 64'd0);

    // Busy hold: fill to 4, then drain in order
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(i);
      step();
      check("busy_we", 64'(mem_we), 64'd0);
    end
    check("busy_count", 64'(count), 64'd4);
    check("busy_full", 64'(full), 64'd1);
    recv_en = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_we", 64'(mem_we), 64'd1);
      check("drain_addr", 64'(mem_addr), 64'(i));
      check("drain_data", mem_wdata, word_of(i));
      check("drain_from", 64'(mem_from), 64'(from_of(i)));
    end
    step();
    check("drain_we_off", 64'(mem_we), 64'd0);
    check("drain_count", 64'(count), 64'd0);
    check("drain_full", 64'(full), 64'd0);

    // Overflow: fifth word dropped
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_push(10 + i);
      step();
    end
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_set", 64'(overflow), 64'd1);
    recv_en = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovf_drain_we", 64'(mem_we), 64'd1);
      check("ovf_drain_addr", 64'(mem_addr), 64'(10 + i));
      check("ovf_drain_data", mem_wdata, word_of(10 + i));
    end
    step();
    check("ovf_no_fifth", 64'(mem_we), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop, 20 streamed words
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(100 + i);
      step();
    end
    mem_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_push(104 + k);
      step();
      check("stream_we", 64'(mem_we), 64'd1);
      check("stream_addr", 64'(mem_addr), 64'(100 + k));
      check("stream_data", mem_wdata, word_of(100 + k));
      check("stream_count", 64'(count), 64'd4);
      check("stream_ovf", 64'(overflow), 64'd0);
    end
    recv_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stream_tail_addr", 64'(mem_addr), 64'(120 + k));
      check("stream_tail_we", 64'(mem_we), 64'd1);
    end
    step();
    check("stream_end_we", 64'(mem_we), 64'd0);
    check("stream_end_count", 64'(count), 64'd0);

    // Bad selector: word still queued, err_from set, set wins over clear
    recv_en = 1'b1; recv_from = 8'h03; recv_addr = 15'd55; recv_word = word_of(55);
    step();
    check("bad_err", 64'(err_from), 64'd1);
    check("bad_count", 64'(count), 64'd1);
    recv_en = 1'b0;
    step();
    check("bad_we", 64'(mem_we), 64'd1);
    check("bad_addr", 64'(mem_addr), 64'd55);
    check("bad_from", 64'(mem_from), 64'h03);
    recv_en = 1'b1; recv_from = 8'h30; recv_addr = 15'd56; recv_word = word_of(56);
    ovf_clr = 1'b1;
    step();
    check("err_set_wins", 64'(err_from), 64'd1);
    recv_en = 1'b0;
    step();
    check("err_cleared", 64'(err_from), 64'd0);
    check("bad2_we", 64'(mem_we), 64'd1);
    check("bad2_addr", 64'(mem_addr), 64'd56);
    ovf_clr = 1'b0;
    step();
    check("bad_end_count", 64'(count), 64'd0);

    // Reset mid-stream with count=3 and a write in flight
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_push(200 + i);
      step();
    end
    recv_en = 1'b0; mem_busy = 1'b0;
    step();
    check("mid_count3", 64'(count), 64'd3);
    check("mid_we1", 64'(mem_we), 64'd1);
    #1 clr = 1'b1;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_we", 64'(mem_we), 64'd0);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    #1 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_write", 64'(mem_we), 64'd0);
    end
    drive_push(300);
    step();
    check("post_rst_push_count", 64'(count), 64'd1);
    recv_en = 1'b0;
    step();
    check("post_rst_we", 64'(mem_we), 64'd1);
    check("post_rst_addr", 64'(mem_addr), 64'd300);
    step();
    check("post_rst_end", 64'(mem_we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
